// File: rtl/gpio_pad_ctrl.sv
// gpio_pad_ctrl
//   Wishbone-attached GPIO pad controller. Per-pin direction and
//   push-pull/open-drain selection, input synchroniser, programmable
//   debounce, rising/falling edge capture into a pending register and a
//   level interrupt.
//
// Ports
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_wb_cyc/stb/we     wishbone slave control
//   i_wb_addr[2:0]      register address
//   i_wb_data[31:0]     write data
//   o_wb_ack            one cycle after every strobe
//   o_wb_stall          tied 0
//   o_wb_data[31:0]     registered read data, valid with ack
//   i_pin[NPINS]        raw pad inputs
//   o_pin[NPINS]        pad output value
//   o_pin_oe[NPINS]     pad output enable (1 = drive)
//   o_int               level interrupt, any pending edge
//
// Register map
//   0 DATA   R: debounced state   W: output latch
//   1 DIR    1 = driven
//   2 ODRAIN 1 = open-drain
//   3 PEND   R: pending edges     W: write-1-to-clear
//   4 RISE_EN
//   5 FALL_EN
//   6 DBNC   debounce threshold (0 = bypass)
//   7 reads 0, writes ignored
module gpio_pad_ctrl #(
    parameter int                    NPINS          = 16,
    parameter int                    SYNC_STAGES    = 2,
    parameter int                    DEBOUNCE_W     = 8,
    parameter logic [DEBOUNCE_W-1:0] DEBOUNCE_RESET = DEBOUNCE_W'(4)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_wb_cyc,
    input  logic             i_wb_stb,
    input  logic             i_wb_we,
    input  logic [2:0]       i_wb_addr,
    input  logic [31:0]      i_wb_data,
    output logic             o_wb_ack,
    output logic             o_wb_stall,
    output logic [31:0]      o_wb_data,
    input  logic [NPINS-1:0] i_pin,
    output logic [NPINS-1:0] o_pin,
    output logic [NPINS-1:0] o_pin_oe,
    output logic             o_int
);

    localparam logic [2:0] A_DATA    = 3'd0;
    localparam logic [2:0] A_DIR     = 3'd1;
    localparam logic [2:0] A_ODRAIN  = 3'd2;
    localparam logic [2:0] A_PEND    = 3'd3;
    localparam logic [2:0] A_RISE_EN = 3'd4;
    localparam logic [2:0] A_FALL_EN = 3'd5;
    localparam logic [2:0] A_DBNC    = 3'd6;

    logic [NPINS-1:0]      out_q, dir_q, odrain_q, pend_q, rise_en_q, fall_en_q;
    logic [DEBOUNCE_W-1:0] dbnc_q;

    logic [NPINS-1:0]      sync_q [SYNC_STAGES];
    logic [NPINS-1:0]      s;
    logic [NPINS-1:0]      stable_q, stable_d_q, stable_nxt;
    logic [DEBOUNCE_W-1:0] cnt_q   [NPINS];
    logic [DEBOUNCE_W-1:0] cnt_nxt [NPINS];

    logic [NPINS-1:0]      wdata;
    logic [NPINS-1:0]      edge_set, pend_clr;
    logic                  wr;
    logic [31:0]           rd_data;

    logic                  unused_ok;
    assign unused_ok = ^{i_wb_cyc, i_wb_data};

    assign wdata      = i_wb_data[NPINS-1:0];
    assign wr         = i_wb_stb & i_wb_we;
    assign o_wb_stall = 1'b0;

    // Open-drain pins only ever pull low; OUT=1 releases the pad.
    assign o_pin    = out_q & ~odrain_q;
    assign o_pin_oe = dir_q & (~odrain_q | ~out_q);

    assign s     = sync_q[SYNC_STAGES-1];
    assign o_int = |pend_q;

    // Edges are taken from the registered stable copy, so PEND lands one
    // cycle after the stable state changes.
    assign edge_set = (stable_q & ~stable_d_q & rise_en_q) |
                      (~stable_q & stable_d_q & fall_en_q);
    assign pend_clr = (wr && i_wb_addr == A_PEND) ? wdata : '0;

    // Comparing against DBNC-1 (rather than incrementing first) also covers a
    // threshold lowered below the current count: the next mismatch commits.
    always_comb begin
        stable_nxt = stable_q;
        for (int k = 0; k < NPINS; k++) begin
            cnt_nxt[k] = '0;
            if (dbnc_q == '0) begin
                stable_nxt[k] = s[k];
            end else if (s[k] != stable_q[k]) begin
                if (cnt_q[k] >= dbnc_q - DEBOUNCE_W'(1)) begin
                    stable_nxt[k] = s[k];
                end else begin
                    cnt_nxt[k] = cnt_q[k] + DEBOUNCE_W'(1);
                end
            end
        end
    end

    always_comb begin
        rd_data = '0;
        case (i_wb_addr)
            A_DATA:    rd_data[NPINS-1:0]      = stable_q;
            A_DIR:     rd_data[NPINS-1:0]      = dir_q;
            A_ODRAIN:  rd_data[NPINS-1:0]      = odrain_q;
            A_PEND:    rd_data[NPINS-1:0]      = pend_q;
            A_RISE_EN: rd_data[NPINS-1:0]      = rise_en_q;
            A_FALL_EN: rd_data[NPINS-1:0]      = fall_en_q;
            A_DBNC:    rd_data[DEBOUNCE_W-1:0] = dbnc_q;
            default:   rd_data                 = '0;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q     <= '0;
            dir_q     <= '0;
            odrain_q  <= '0;
            rise_en_q <= '0;
            fall_en_q <= '0;
            dbnc_q    <= DEBOUNCE_RESET;
        end else if (wr) begin
            case (i_wb_addr)
                A_DATA:    out_q     <= wdata;
                A_DIR:     dir_q     <= wdata;
                A_ODRAIN:  odrain_q  <= wdata;
                A_RISE_EN: rise_en_q <= wdata;
                A_FALL_EN: fall_en_q <= wdata;
                A_DBNC:    dbnc_q    <= i_wb_data[DEBOUNCE_W-1:0];
                default:   ;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_wb_ack  <= 1'b0;
            o_wb_data <= '0;
        end else begin
            o_wb_ack <= i_wb_stb;
            if (i_wb_stb) begin
                o_wb_data <= rd_data;
            end
        end
    end

    // Set wins over a same-cycle write-1-to-clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pend_q <= '0;
        end else begin
            pend_q <= (pend_q & ~pend_clr) | edge_set;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            for (int k = 0; k < NPINS; k++) begin
                cnt_q[k] <= '0;
            end
            stable_q   <= '0;
            stable_d_q <= '0;
        end else begin
            sync_q[0] <= i_pin;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            for (int k = 0; k < NPINS; k++) begin
                cnt_q[k] <= cnt_nxt[k];
            end
            stable_q   <= stable_nxt;
            stable_d_q <= stable_q;
        end
    end

endmodule

// File: tb/tb_gpio_pad_ctrl.sv
// Directed bench for gpio_pad_ctrl with default parameters. Read
// expectations are queued when the strobe is issued and compared when the
// acknowledge returns.
module tb_gpio_pad_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_wb_cyc = 1'b0;
    logic        i_wb_stb = 1'b0;
    logic        i_wb_we = 1'b0;
    logic [2:0]  i_wb_addr = '0;
    logic [31:0] i_wb_data = '0;
    logic        o_wb_ack;
    logic        o_wb_stall;
    logic [31:0] o_wb_data;
    logic [15:0] i_pin = '0;
    logic [15:0] o_pin;
    logic [15:0] o_pin_oe;
    logic        o_int;

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];

    gpio_pad_ctrl dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_wb_cyc   (i_wb_cyc),
        .i_wb_stb   (i_wb_stb),
        .i_wb_we    (i_wb_we),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_wb_ack   (o_wb_ack),
        .o_wb_stall (o_wb_stall),
        .o_wb_data  (o_wb_data),
        .i_pin      (i_pin),
        .o_pin      (o_pin),
        .o_pin_oe   (o_pin_oe),
        .o_int      (o_int)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2ms;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // One strobe; a read pushes its expectation, which is popped at ack.
    task automatic wb_xfer(input logic we, input logic [2:0] addr, input logic [31:0] data,
                           input logic [31:0] exp, input string tag);
        int n;
        logic [31:0] e;
        string t;
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = we;
        i_wb_addr = addr;
        i_wb_data = data;
        if (!we) begin
            exp_q.push_back(exp);
            tag_q.push_back(tag);
        end
        tick();
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        i_wb_we  = 1'b0;
        n = 0;
        while (!o_wb_ack && n < 4) begin
            tick();
            n++;
        end
        check({"ack_", tag}, {31'd0, o_wb_ack}, 32'd1);
        if (!we) begin
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            if (o_wb_ack) check(t, o_wb_data, e);
        end
    endtask

    task automatic wr(input logic [2:0] addr, input logic [31:0] data, input string tag);
        wb_xfer(1'b1, addr, data, 32'd0, tag);
    endtask

    task automatic rd(input logic [2:0] addr, input logic [31:0] exp, input string tag);
        wb_xfer(1'b0, addr, 32'd0, exp, tag);
    endtask

    task automatic read_all_reset(input string pfx);
        rd(3'd0, 32'h0, {pfx, "_data"});
        rd(3'd1, 32'h0, {pfx, "_dir"});
        rd(3'd2, 32'h0, {pfx, "_odrain"});
        rd(3'd3, 32'h0, {pfx, "_pend"});
        rd(3'd4, 32'h0, {pfx, "_rise_en"});
        rd(3'd5, 32'h0, {pfx, "_fall_en"});
        rd(3'd6, 32'h4, {pfx, "_dbnc"});
        rd(3'd7, 32'h0, {pfx, "_addr7"});
    endtask

    initial begin
        // reset state
        tick();
        tick();
        check("rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("rst_rdata", o_wb_data, 32'd0);
        check("rst_oe", {16'd0, o_pin_oe}, 32'd0);
        check("rst_int", {31'd0, o_int}, 32'd0);
        i_rst = 1'b0;
        tick();
        read_all_reset("rst");

        // upper bits read 0
        wr(3'd7, 32'hFFFF_FFFF, "w_addr7");
        rd(3'd7, 32'h0, "addr7_ignored");
        wr(3'd4, 32'hFFFF_FFFF, "w_rise_all");
        rd(3'd4, 32'h0000_FFFF, "rise_en_width");
        wr(3'd4, 32'h0, "w_rise_0");
        wr(3'd6, 32'h0000_01FF, "w_dbnc_wide");
        rd(3'd6, 32'h0000_00FF, "dbnc_width");

        // pad drive
        wr(3'd1, 32'h3, "w_dir");
        wr(3'd2, 32'h1, "w_odrain");
        wr(3'd0, 32'h3, "w_out3");
        check("pad_pin_out3", {16'd0, o_pin}, 32'h2);
        check("pad_oe_out3", {16'd0, o_pin_oe}, 32'h2);
        wr(3'd0, 32'h0, "w_out0");
        check("pad_pin_out0", {16'd0, o_pin}, 32'h0);
        check("pad_oe_out0", {16'd0, o_pin_oe}, 32'h3);

        // step latency with DBNC = 4: DATA after 6 edges, PEND after 7
        wr(3'd6, 32'h4, "w_dbnc4");
        wr(3'd4, 32'h4, "w_rise4");
        i_pin[2] = 1'b1;
        repeat (5) tick();
        rd(3'd0, 32'h0, "step_data_e5");
        check("step_int_e6", {31'd0, o_int}, 32'd0);
        rd(3'd0, 32'h4, "step_data_e6");
        check("step_int_e7", {31'd0, o_int}, 32'd1);
        rd(3'd3, 32'h4, "step_pend");

        // 3-cycle glitch rejected at DBNC = 4
        wr(3'd4, 32'h24, "w_rise24");
        i_pin[5] = 1'b1;
        repeat (3) tick();
        i_pin[5] = 1'b0;
        repeat (6) tick();
        rd(3'd0, 32'h4, "glitch_data");
        rd(3'd3, 32'h4, "glitch_pend");

        // same pulse in bypass follows the pin
        wr(3'd6, 32'h0, "w_dbnc0");
        i_pin[5] = 1'b1;
        repeat (3) tick();
        i_pin[5] = 1'b0;
        rd(3'd0, 32'h24, "bypass_data_hi_a");
        rd(3'd0, 32'h24, "bypass_data_hi_b");
        repeat (5) tick();
        rd(3'd0, 32'h4, "bypass_data_lo");
        rd(3'd3, 32'h24, "bypass_pend");
        wr(3'd3, 32'h20, "w_clr20");
        rd(3'd3, 32'h4, "pend_after_clr20");

        // set wins over same-cycle clear
        wr(3'd5, 32'h4, "w_fall4");
        i_pin[2] = 1'b0;
        repeat (3) tick();
        wr(3'd3, 32'h4, "w_clr_collide");
        rd(3'd3, 32'h4, "pend_set_wins");
        check("int_set_wins", {31'd0, o_int}, 32'd1);
        wr(3'd3, 32'h4, "w_clr4");
        rd(3'd3, 32'h0, "pend_cleared");
        check("int_cleared", {31'd0, o_int}, 32'd0);

        // reset mid-count with an ack in flight
        wr(3'd6, 32'h4, "w_dbnc4b");
        i_pin[7] = 1'b1;
        repeat (5) tick();
        i_wb_cyc  = 1'b1;
        i_wb_stb  = 1'b1;
        i_wb_we   = 1'b0;
        i_wb_addr = 3'd1;
        #2;
        i_rst = 1'b1;
        #1;
        i_wb_cyc = 1'b0;
        i_wb_stb = 1'b0;
        tick();
        check("mid_rst_ack", {31'd0, o_wb_ack}, 32'd0);
        check("mid_rst_rdata", o_wb_data, 32'd0);
        check("mid_rst_oe", {16'd0, o_pin_oe}, 32'd0);
        i_rst = 1'b0;
        read_all_reset("mid_rst");
        check("mid_rst_int", {31'd0, o_int}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
